// File: rtl/uart_hex_rx_pkg.sv
// Shared definitions for the UART hex receive path: RX FSM states, ASCII
// constants, bit-period helper and hex digit decoder.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state, 8E1 framing).
package uart_hex_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_RECOVER
  } rx_state_t;

  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_LF      = 8'h0A;
  localparam logic [7:0] ASCII_0       = 8'h30;
  localparam logic [7:0] ASCII_9       = 8'h39;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_UPPER_F = 8'h46;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_LOWER_F = 8'h66;

  // Clock cycles per serial bit; shared with the transmit side.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // Returns {is_hex, nibble}; nibble is 0 when the byte is not a hex digit.
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    logic [4:0] r;
    r = '0;
    if (b >= ASCII_0 && b <= ASCII_9)
      r = {1'b1, 4'(b - ASCII_0)};
    else if (b >= ASCII_UPPER_A && b <= ASCII_UPPER_F)
      r = {1'b1, 4'(b - ASCII_UPPER_A + 8'd10)};
    else if (b >= ASCII_LOWER_A && b <= ASCII_LOWER_F)
      r = {1'b1, 4'(b - ASCII_LOWER_A + 8'd10)};
    return r;
  endfunction

endpackage

// File: rtl/uart_hex_rx_core.sv
// UART receive core: 2-FF synchroniser, baud counter and RX FSM.
// 8N1 by default; 8E1 when UART_RX_PARITY_EN is defined.
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       frame_err,
  output logic       parity_err
);
  import uart_hex_rx_pkg::*;

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync1;
  logic             line;
  logic             line_q;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             drop;

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  logic par_strobe;
  assign drop       = par_bad;
  assign parity_err = par_strobe;
`else
  assign drop       = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Synchronise the asynchronous line; resets to idle-high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1  <= 1'b1;
      line   <= 1'b1;
      line_q <= 1'b1;
    end else begin
      sync1  <= rxd;
      line   <= sync1;
      line_q <= line;
    end
  end

  // RX FSM with bit-centre sampling and registered strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      frame_err     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad       <= 1'b0;
      par_strobe    <= 1'b0;
`endif
    end else begin
      rx_byte_valid <= 1'b0;
      frame_err     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_strobe    <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (line_q && !line) begin
            state   <= ST_START;
            cnt     <= '0;
            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
          end
        end
        ST_START: begin
          if (cnt == HALF_M1) begin
            cnt   <= '0;
            state <= line ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shreg   <= {line, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt == FULL_M1) begin
            cnt        <= '0;
            par_bad    <= (^shreg) != line;
            par_strobe <= (^shreg) != line;
            state      <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (line) begin
              if (!drop) begin
                rx_byte       <= shreg;
                rx_byte_valid <= 1'b1;
              end
              state <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_RECOVER;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RECOVER: begin
          if (line) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_hex_rx.sv
// Serial hex operand receiver: uart_rx_core plus an ASCII hex parser that
// accumulates digits and delivers an operand on CR or LF.
// Optional feature macro: UART_RX_PARITY_EN (8E1 framing, drives parity_err).
module uart_hex_rx #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned MAX_DIGITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        UART_RXD,
  output logic [7:0]  rx_byte,
  output logic        rx_byte_valid,
  output logic [63:0] value,
  output logic        value_valid,
  output logic [4:0]  digit_count,
  output logic        frame_err,
  output logic        parse_err,
  output logic        overflow_err,
  output logic        parity_err
);
  import uart_hex_rx_pkg::*;

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned ACC_W        = 4 * MAX_DIGITS;

  logic [ACC_W-1:0] acc;
  logic [4:0]       dec;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clk          (clk),
    .rst          (rst),
    .rxd          (UART_RXD),
    .rx_byte      (rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .frame_err    (frame_err),
    .parity_err   (parity_err)
  );

  assign dec = hex_decode(rx_byte);

  // Hex parser: shift in digits, publish on terminator, discard on junk.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc          <= '0;
      value        <= '0;
      value_valid  <= 1'b0;
      digit_count  <= '0;
      parse_err    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      parse_err   <= 1'b0;
      if (rx_byte_valid) begin
        if (dec[4]) begin
          acc <= {acc[ACC_W-5:0], dec[3:0]};
          if (digit_count == 5'(MAX_DIGITS))
            overflow_err <= 1'b1;
          else
            digit_count <= digit_count + 1'b1;
        end else if (rx_byte == ASCII_CR || rx_byte == ASCII_LF) begin
          if (digit_count != '0) begin
            value        <= 64'(acc);
            value_valid  <= 1'b1;
            acc          <= '0;
            digit_count  <= '0;
            overflow_err <= 1'b0;
          end
        end else begin
          parse_err    <= 1'b1;
          acc          <= '0;
          digit_count  <= '0;
          overflow_err <= 1'b0;
        end
      end
    end
  end

endmodule
